// File: rtl/snoop_responder_pkg.sv
// Shared definitions for the snoop responder and the local cache controller.
// Holds the bus function codes, the MSI line-state codes and the responder FSM states.
// The FLUSH state exists only when SNOOP_WB_EN is defined.
package snoop_responder_pkg;

  // Bus function codes
  localparam logic [1:0] FuncPRead  = 2'b00;
  localparam logic [1:0] FuncPWrite = 2'b01;
  localparam logic [1:0] FuncBRead  = 2'b10;
  localparam logic [1:0] FuncBWrite = 2'b11;

  // MSI line-state codes
  localparam logic [1:0] StatExcl = 2'b11;
  localparam logic [1:0] StatShrd = 2'b10;
  localparam logic [1:0] StatInvl = 2'b00;

  // Width of the data-latency counter
  localparam int unsigned CntW = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLookup = 3'd1,
    StSupply = 3'd2,
`ifdef SNOOP_WB_EN
    StFlush  = 3'd3,
`endif
    StUpdate = 3'd4
  } snoop_state_e;

  // Only remote bus traffic is snooped; processor-side codes are ignored.
  function automatic logic is_bus_snoop(logic [1:0] func);
    return !(func == FuncPRead || func == FuncPWrite);
  endfunction

endpackage

// File: rtl/snoop_lat_counter.sv
// Loadable down-counter timing the data-array read latency.
// Ports:
//   clk, reset (async, active-low)
//   load     - load load_val (has priority over en)
//   load_val - start value
//   en       - count down by one; holds at zero, never wraps
//   done     - counter is zero
module snoop_lat_counter
  import snoop_responder_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CntW-1:0] load_val,
  input  logic            en,
  output logic            done
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/snoop_responder.sv
// Snoop responder: services b_read / b_write snoops from other caches against the
// local tag/state/data arrays, supplies hit lines cache-to-cache and downgrades MSI state.
// Ports:
//   clk, reset (async, active-low)
//   snoop_req/func/addr  - snoop bus request, held high by the requester
//   tag_rd, tag_addr     - tag lookup strobe and latched address
//   tag_hit, line_stat   - lookup result, sampled at the end of the tag_rd cycle
//   data_rd, data_oe     - data-array read and bus drive
//   snoop_hit            - local cache is supplying the line
//   snoop_ready          - one-cycle pulse, bus data valid
//   stat_we, stat_new    - line-state write strobe and new state
//   mem_wr, mem_cs       - write-back request (only with SNOOP_WB_EN, else tied 0)
//   mem_ready            - write-back completion
//   busy                 - responder not idle; stalls the local controller
// Define SNOOP_WB_EN to write excl lines back to memory while supplying them.
// All outputs decode registered state only.
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              snoop_req,
  input  logic [1:0]        snoop_func,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              tag_rd,
  output logic [ADDR_W-1:0] tag_addr,
  input  logic              tag_hit,
  input  logic [1:0]        line_stat,
  output logic              data_rd,
  output logic              data_oe,
  output logic              snoop_hit,
  output logic              snoop_ready,
  output logic              stat_we,
  output logic [1:0]        stat_new,
  output logic              mem_wr,
  output logic              mem_cs,
  input  logic              mem_ready,
  output logic              busy
);

  localparam logic [CntW-1:0] LatLoad = CntW'(DATA_LAT - 1);

  snoop_state_e      state_q, state_d;
  logic [1:0]        func_q, func_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              armed_q, armed_d;
  logic              cnt_load, cnt_en, cnt_done;
  logic              flush_act;
`ifdef SNOOP_WB_EN
  logic              excl_q, excl_d;
`else
  logic              unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  snoop_lat_counter u_lat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LatLoad),
    .en       (cnt_en),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      func_q  <= '0;
      addr_q  <= '0;
      armed_q <= 1'b1;
`ifdef SNOOP_WB_EN
      excl_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      addr_q  <= addr_d;
      armed_q <= armed_d;
`ifdef SNOOP_WB_EN
      excl_q  <= excl_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    addr_d   = addr_q;
    // Re-arm once the requester drops its request, so a held request is serviced once.
    armed_d  = armed_q | ~snoop_req;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
`ifdef SNOOP_WB_EN
    excl_d   = excl_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (snoop_req && armed_q && is_bus_snoop(snoop_func)) begin
          func_d  = snoop_func;
          addr_d  = snoop_addr;
          armed_d = 1'b0;
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (tag_hit && (line_stat == StatExcl || line_stat == StatShrd)) begin
          if (func_q == FuncBRead) begin
            state_d  = StSupply;
            cnt_load = 1'b1;
`ifdef SNOOP_WB_EN
            excl_d   = (line_stat == StatExcl);
`endif
          end else begin
            state_d = StUpdate;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StSupply: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
`ifdef SNOOP_WB_EN
          state_d = excl_q ? StFlush : StUpdate;
`else
          state_d = StUpdate;
`endif
        end
      end
`ifdef SNOOP_WB_EN
      StFlush: begin
        if (mem_ready) begin
          state_d = StUpdate;
        end
      end
`endif
      StUpdate: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    tag_rd      = 1'b0;
    data_rd     = 1'b0;
    data_oe     = 1'b0;
    snoop_hit   = 1'b0;
    snoop_ready = 1'b0;
    stat_we     = 1'b0;
    stat_new    = StatInvl;
    flush_act   = 1'b0;
    unique case (state_q)
      StLookup: tag_rd = 1'b1;
      StSupply: begin
        data_rd     = 1'b1;
        data_oe     = 1'b1;
        snoop_hit   = 1'b1;
        snoop_ready = cnt_done;
      end
`ifdef SNOOP_WB_EN
      StFlush: begin
        data_oe   = 1'b1;
        snoop_hit = 1'b1;
        flush_act = 1'b1;
      end
`endif
      StUpdate: begin
        stat_we  = 1'b1;
        stat_new = (func_q == FuncBRead) ? StatShrd : StatInvl;
      end
      default: ;
    endcase
  end

  assign tag_addr = addr_q;
  assign busy     = (state_q != StIdle);
  assign mem_wr   = flush_act;
  assign mem_cs   = flush_act;

endmodule

// File: tb/tb_snoop_responder.sv
module tb_snoop_responder;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DATA_LAT = 2;
`ifdef SNOOP_WB_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              snoop_req;
  logic [1:0]        snoop_func;
  logic [ADDR_W-1:0] snoop_addr;
  logic              tag_rd;
  logic [ADDR_W-1:0] tag_addr;
  logic              tag_hit;
  logic [1:0]        line_stat;
  logic              data_rd, data_oe, snoop_hit, snoop_ready, stat_we;
  logic [1:0]        stat_new;
  logic              mem_wr, mem_cs, mem_ready, busy;

  snoop_responder #(.ADDR_W(ADDR_W), .DATA_LAT(DATA_LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .snoop_req   (snoop_req),
    .snoop_func  (snoop_func),
    .snoop_addr  (snoop_addr),
    .tag_rd      (tag_rd),
    .tag_addr    (tag_addr),
    .tag_hit     (tag_hit),
    .line_stat   (line_stat),
    .data_rd     (data_rd),
    .data_oe     (data_oe),
    .snoop_hit   (snoop_hit),
    .snoop_ready (snoop_ready),
    .stat_we     (stat_we),
    .stat_new    (stat_new),
    .mem_wr      (mem_wr),
    .mem_cs      (mem_cs),
    .mem_ready   (mem_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // {tag_rd,data_rd,data_oe,snoop_hit,snoop_ready,stat_we,stat_new[1:0],mem_wr,mem_cs,busy}
  logic [10:0] obs;
  assign obs = {tag_rd, data_rd, data_oe, snoop_hit, snoop_ready, stat_we, stat_new,
                mem_wr, mem_cs, busy};

  // Per-cycle phases of a transaction as seen on the outputs
  typedef enum int {PIdle, PLook, PSup, PSupLast, PFlush, PUpdR, PUpdW} phase_e;

  typedef struct {
    logic [1:0]        func;
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [1:0]        stat;
    int                mdelay;
    int                exp_busy;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [ADDR_W-1:0] exp_addr;
  phase_e exp_q[$];

  function automatic logic [10:0] phase_out(phase_e p);
    case (p)
      PLook:    return 11'b10000000001;
      PSup:     return 11'b01110000001;
      PSupLast: return 11'b01111000001;
      PFlush:   return 11'b00110000111;
      PUpdR:    return 11'b00000110001;
      PUpdW:    return 11'b00000100001;
      default:  return 11'b00000000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected phase sequence after the accept edge, straight from the protocol rules.
  task automatic build(input logic [1:0] f, input logic hit, input logic [1:0] st,
                       input int md);
    exp_q.delete();
    if (!(f == 2'b10 || f == 2'b11)) return;
    exp_q.push_back(PLook);
    if (!(hit && (st == 2'b11 || st == 2'b10))) return;
    if (f == 2'b11) begin
      exp_q.push_back(PUpdW);
      return;
    end
    for (int k = 0; k < int'(DATA_LAT) - 1; k++) exp_q.push_back(PSup);
    exp_q.push_back(PSupLast);
    if (WB == 1 && st == 2'b11) for (int k = 0; k < md; k++) exp_q.push_back(PFlush);
    exp_q.push_back(PUpdR);
  endtask

  // Drives a request at the current negedge, checks every following cycle, then releases it.
  task automatic run_txn(input logic [1:0] f, input logic [ADDR_W-1:0] a, input logic hit,
                         input logic [1:0] st, input int md, input int hold,
                         output int busy_cnt);
    int n;
    int tagrd_cnt;
    snoop_req  = 1'b1;
    snoop_func = f;
    snoop_addr = a;
    tag_hit    = hit;
    line_stat  = st;
    mem_ready  = 1'b0;
    build(f, hit, st, md);
    if (f == 2'b10 || f == 2'b11) exp_addr = a;
    busy_cnt  = 0;
    tagrd_cnt = 0;
    n = exp_q.size() + hold;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("outputs", 32'(obs), (i < exp_q.size()) ? 32'(phase_out(exp_q[i])) : 32'd0);
      check("tag_addr", 32'(tag_addr), 32'(exp_addr));
      busy_cnt  += int'(busy);
      tagrd_cnt += int'(tag_rd);
      // Memory answers in the last expected FLUSH cycle.
      mem_ready = (i < exp_q.size()) && (exp_q[i] == PFlush) &&
                  ((i + 1 >= exp_q.size()) || (exp_q[i+1] != PFlush));
    end
    check("tag_rd_once", 32'(tagrd_cnt), (exp_q.size() > 0) ? 32'd1 : 32'd0);
    snoop_req = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[10];
  int   bc;

  initial begin
    vecs[0] = '{2'b10, 8'h3C, 1'b1, 2'b11, 4, int'(DATA_LAT) + 2 + WB * 4};
    vecs[1] = '{2'b10, 8'h41, 1'b1, 2'b10, 2, int'(DATA_LAT) + 2};
    vecs[2] = '{2'b11, 8'h7E, 1'b1, 2'b10, 1, 2};
    vecs[3] = '{2'b11, 8'h80, 1'b1, 2'b11, 1, 2};
    vecs[4] = '{2'b10, 8'h12, 1'b0, 2'b11, 1, 1};
    vecs[5] = '{2'b10, 8'h13, 1'b1, 2'b00, 1, 1};
    vecs[6] = '{2'b11, 8'hF0, 1'b0, 2'b10, 1, 1};
    vecs[7] = '{2'b00, 8'hAA, 1'b1, 2'b11, 1, 0};
    vecs[8] = '{2'b01, 8'h55, 1'b1, 2'b10, 1, 0};
    vecs[9] = '{2'b10, 8'hFF, 1'b1, 2'b11, 1, int'(DATA_LAT) + 2 + WB * 1};

    // Reset with a request already held high
    reset      = 1'b0;
    snoop_req  = 1'b1;
    snoop_func = 2'b10;
    snoop_addr = 8'h3C;
    tag_hit    = 1'b1;
    line_stat  = 2'b11;
    mem_ready  = 1'b0;
    exp_addr   = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", 32'(obs), 32'd0);
    check("reset_tag_addr", 32'(tag_addr), 32'd0);
    reset = 1'b1;
    run_txn(2'b10, 8'h3C, 1'b1, 2'b11, 4, 3, bc);
    check("busy_after_reset", 32'(bc), 32'(int'(DATA_LAT) + 2 + WB * 4));

    // Directed table
    for (int v = 0; v < 10; v++) begin
      run_txn(vecs[v].func, vecs[v].addr, vecs[v].hit, vecs[v].stat, vecs[v].mdelay, 2, bc);
      check($sformatf("busy_cycles[%0d]", v), 32'(bc), 32'(vecs[v].exp_busy));
    end

    // Reset asserted while supplying data
    snoop_req  = 1'b1;
    snoop_func = 2'b10;
    snoop_addr = 8'h5A;
    tag_hit    = 1'b1;
    line_stat  = 2'b10;
    @(negedge clk);
    @(negedge clk);
    check("supply_before_reset", 32'(obs), 32'(phase_out(PSup)));
    reset = 1'b0;
    #1;
    check("abort_outs", 32'(obs), 32'd0);
    check("abort_tag_addr", 32'(tag_addr), 32'd0);
    exp_addr = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_stat_we", 32'(stat_we), 32'd0);
    end
    snoop_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    run_txn(2'b10, 8'h5A, 1'b1, 2'b10, 1, 1, bc);
    check("busy_after_abort", 32'(bc), 32'(int'(DATA_LAT) + 2));

    // Randomized transactions against the phase model
    for (int r = 0; r < 40; r++) begin
      logic [1:0] f;
      logic [1:0] st;
      int         sel;
      f   = 2'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 2));
      st  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b10 : 2'b11;
      run_txn(f, 8'($urandom), 1'($urandom), st, int'($urandom_range(1, 5)),
              int'($urandom_range(1, 2)), bc);
      check("rand_busy", 32'(bc), 32'(exp_q.size()));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
